// File: rtl/apb_pkg.sv
// Shared definitions for the APB scratch-memory completer: FSM encoding,
// PPROT bit positions and the byte-to-word address shift.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int PRIV  = 0;
  localparam int NSEC  = 1;
  localparam int INSTR = 2;

  // Number of byte-offset bits below the word index for a DW-bit bus.
  function automatic int apb_lsb(input int dw);
    return $clog2(dw) - 3;
  endfunction

endpackage

// File: rtl/sram_bytewe.sv
// Single-port word memory with per-byte write enables and a registered read.
// Each byte lane is its own array so every lane maps cleanly onto block RAM.
module sram_bytewe #(
  parameter int DW     = 32,
  parameter int WORDS  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [DW/8-1:0]   i_be,
  input  logic [DW-1:0]     i_wdata,
  output logic [DW-1:0]     o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < DW / 8; gi++) begin : g_lane
      logic [7:0] r_mem [WORDS];
      logic [7:0] r_q;

      // Read output only moves when a read is issued, so it holds between reads.
      always_ff @(posedge i_clk) begin
        if (i_we && i_be[gi]) begin
          r_mem[i_addr] <= i_wdata[gi*8 +: 8];
        end
        if (i_re) begin
          r_q <= r_mem[i_addr];
        end
      end

      assign o_rdata[gi*8 +: 8] = r_q;
    end
  endgenerate

endmodule

// File: rtl/apb_sram.sv
// APB4 completer over a byte-writable memory with programmable wait states,
// out-of-range PSLVERR and an optional privileged-only write region.
module apb_sram
  import apb_pkg::*;
#(
  parameter int C_APB_ADDR_WIDTH = 12,
  parameter int C_APB_DATA_WIDTH = 32,
  parameter int MEM_WORDS        = 1024,
  parameter int WAIT_STATES      = 0,
  parameter int OPT_WPROT        = 0,
  parameter int WPROT_WORDS      = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  output logic                          PREADY,
  input  logic [C_APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic                          PWRITE,
  input  logic [C_APB_DATA_WIDTH-1:0]   PWDATA,
  input  logic [C_APB_DATA_WIDTH/8-1:0] PWSTRB,
  input  logic [2:0]                    PPROT,
  output logic [C_APB_DATA_WIDTH-1:0]   PRDATA,
  output logic                          PSLVERR
);

  localparam int AW     = C_APB_ADDR_WIDTH;
  localparam int DW     = C_APB_DATA_WIDTH;
  localparam int NB     = DW / 8;
  localparam int APBLSB = apb_lsb(DW);
  localparam int IW     = AW - APBLSB;
  localparam int MW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_pready;
  logic            r_pslverr;
  logic            r_rd_zero;
  logic [MW-1:0]   r_idx;
  logic            r_write;
  logic [NB-1:0]   r_strb;
  logic [DW-1:0]   r_wdata;
  logic            r_err;

  logic [IW-1:0]   w_idx;
  logic            w_setup;
  logic            w_oor;
  logic            w_wprot;
  logic            w_err;
  logic            w_re;
  logic            w_we;
  logic [MW-1:0]   w_addr;
  logic [DW-1:0]   w_q;
  logic            w_unused;

  assign w_idx    = PADDR[AW-1:APBLSB];
  assign w_setup  = PSEL && !PENABLE;
  assign w_oor    = 32'(w_idx) >= MEM_WORDS;
  assign w_wprot  = (OPT_WPROT != 0) && PWRITE && !PPROT[PRIV] && (32'(w_idx) < WPROT_WORDS);
  assign w_err    = w_oor || w_wprot;
  assign w_unused = ^{PADDR, PPROT};

  // The memory read is issued on the edge that enters RESP, from PADDR when
  // there are no wait states, otherwise from the latched index.
  assign w_re = ((r_state == IDLE) && w_setup && !PWRITE && !w_err && (WAIT_STATES == 0)) ||
                ((r_state == WAIT) && PSEL && (r_cnt == 4'd0) && !r_write && !r_err);
  assign w_we   = (r_state == RESP) && PSEL && r_write && !r_err;
  assign w_addr = (r_state == IDLE) ? w_idx[MW-1:0] : r_idx;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_rd_zero <= 1'b1;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_strb    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_idx   <= w_idx[MW-1:0];
            r_write <= PWRITE;
            r_strb  <= PWSTRB;
            r_wdata <= PWDATA;
            r_err   <= w_err;
            if (WAIT_STATES == 0) begin
              r_state   <= RESP;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              if (!PWRITE) r_rd_zero <= w_err;
            end else begin
              r_cnt   <= 4'(WAIT_STATES - 1);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state   <= RESP;
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            if (!r_write) r_rd_zero <= r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sram_bytewe #(
    .DW     (DW),
    .WORDS  (MEM_WORDS),
    .ADDR_W (MW)
  ) u_mem (
    .i_clk   (PCLK),
    .i_addr  (w_addr),
    .i_re    (w_re),
    .i_we    (w_we),
    .i_be    (r_strb),
    .i_wdata (r_wdata),
    .o_rdata (w_q)
  );

  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;
  assign PRDATA  = r_rd_zero ? '0 : w_q;

endmodule

// File: tb/tb_apb_sram.sv
// Directed and scoreboard-checked bench for apb_sram: three instances cover
// zero wait states with range/write-protect errors, 3 and 5 wait states.
module tb_apb_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic [2:0]  pprot;
  logic [2:0]  pready;
  logic [2:0]  pslverr;
  logic [31:0] prdata [3];

  int n_checks = 0;
  int n_pass   = 0;
  int ws_tab [3] = '{0, 3, 5};
  logic [31:0] model [256];

  always #5 clk = ~clk;

  apb_sram #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32), .MEM_WORDS(256),
             .WAIT_STATES(0), .OPT_WPROT(1), .WPROT_WORDS(16)) u_a (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PREADY(pready[0]),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PWSTRB(pwstrb), .PPROT(pprot),
    .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  apb_sram #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32), .MEM_WORDS(1024),
             .WAIT_STATES(3), .OPT_WPROT(0), .WPROT_WORDS(16)) u_b (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PREADY(pready[1]),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PWSTRB(pwstrb), .PPROT(pprot),
    .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  apb_sram #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32), .MEM_WORDS(1024),
             .WAIT_STATES(5), .OPT_WPROT(0), .WPROT_WORDS(16)) u_c (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PREADY(pready[2]),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PWSTRB(pwstrb), .PPROT(pprot),
    .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_setup(input int d, input logic wr, input logic [11:0] a,
                             input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pwstrb  = st;
    pprot   = pr;
  endtask

  // Entered and left #1 after a rising edge so transfers can run back-to-back.
  task automatic apb_xfer(input int d, input logic wr, input logic [11:0] a,
                          input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                          output logic [31:0] rd, output logic err, output int waits);
    bit done;
    drive_setup(d, wr, a, wd, st, pr);
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pready[d]) done = 1'b1;
      else begin
        check_eq("pslverr_while_wait", 64'(pslverr[d]), 64'd0);
        waits++;
      end
    end
    if (!done) check_eq("pready_timeout", 64'(pready[d]), 64'd1);
    rd  = prdata[d];
    err = pslverr[d];
    $display("xfer dut%0d %s addr=0x%03h wdata=0x%08h strb=%b prot=%b -> rdata=0x%08h err=%0b waits=%0d",
             d, wr ? "WR" : "RD", a, wd, st, pr, rd, err, waits);
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
  endtask

  task automatic do_write(input int d, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input logic exp_err,
                          input string tag);
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb_xfer(d, 1'b1, a, wd, st, pr, rd, err, waits);
    check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
    check_eq({tag, "_waits"}, 64'(waits), 64'(ws_tab[d]));
  endtask

  task automatic do_read(input int d, input logic [11:0] a, input logic [31:0] exp_rd,
                         input logic exp_err, input string tag);
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb_xfer(d, 1'b0, a, 32'h0, 4'h0, 3'b000, rd, err, waits);
    check_eq({tag, "_data"}, 64'(rd), 64'(exp_rd));
    check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
    check_eq({tag, "_waits"}, 64'(waits), 64'(ws_tab[d]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd;
    logic        err, wr, exp_err;
    logic [3:0]  st;
    logic [2:0]  pr;
    logic [11:0] a;
    int          waits, idx;

    rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pwstrb = '0; pprot = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq("reset_pready", 64'(pready[d]), 64'd0);
      check_eq("reset_pslverr", 64'(pslverr[d]), 64'd0);
      check_eq("reset_prdata", 64'(prdata[d]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: basic write/read and PRDATA holding across a write.
    do_write(0, 12'h010, 32'h12345678, 4'hF, 3'b001, 1'b0, "t1_wr");
    do_read (0, 12'h010, 32'h12345678, 1'b0, "t1_rd");
    do_write(0, 12'h000, 32'h0BADF00D, 4'hF, 3'b001, 1'b0, "t1_wr0");
    check_eq("prdata_hold_after_wr", 64'(prdata[0]), 64'h12345678);

    // Out-of-range accesses and the last implemented word.
    do_write(0, 12'h400, 32'hDEADBEEF, 4'hF, 3'b001, 1'b1, "t3_oor_wr");
    do_read (0, 12'h400, 32'h0, 1'b1, "t3_oor_rd");
    do_read (0, 12'h000, 32'h0BADF00D, 1'b0, "t3_rd0");
    do_write(0, 12'h3FC, 32'hFEEDFACE, 4'hF, 3'b001, 1'b0, "t3_last_wr");
    do_read (0, 12'h3FD, 32'hFEEDFACE, 1'b0, "t3_last_rd");
    do_read (0, 12'hFFC, 32'h0, 1'b1, "t3_top_rd");

    // Write-protect region boundaries and zero-strobe write.
    do_write(0, 12'h004, 32'h0000A5A5, 4'hF, 3'b001, 1'b0, "t4_init");
    do_write(0, 12'h004, 32'h55555555, 4'hF, 3'b000, 1'b1, "t4_wp_wr");
    do_read (0, 12'h004, 32'h0000A5A5, 1'b0, "t4_wp_rd");
    do_write(0, 12'h004, 32'h55555555, 4'hF, 3'b001, 1'b0, "t4_priv_wr");
    do_read (0, 12'h004, 32'h55555555, 1'b0, "t4_priv_rd");
    do_write(0, 12'h03C, 32'h00000001, 4'hF, 3'b110, 1'b1, "t4_w15_wr");
    do_write(0, 12'h040, 32'h00000077, 4'hF, 3'b000, 1'b0, "t4_w16_wr");
    do_write(0, 12'h040, 32'hFFFFFFFF, 4'h0, 3'b000, 1'b0, "t4_nostrb_wr");
    do_read (0, 12'h040, 32'h00000077, 1'b0, "t4_w16_rd");

    // Three wait states with a partial-strobe write.
    do_write(1, 12'h010, 32'h12345678, 4'hF, 3'b000, 1'b0, "t2_wr");
    do_read (1, 12'h010, 32'h12345678, 1'b0, "t2_rd");
    do_write(1, 12'h010, 32'hAABBCCDD, 4'b0010, 3'b000, 1'b0, "t2_strb_wr");
    do_read (1, 12'h010, 32'h1234CC78, 1'b0, "t2_strb_rd");

    // PSEL dropped during WAIT: transfer abandoned, nothing written.
    drive_setup(1, 1'b1, 12'h010, 32'hCAFEF00D, 4'hF, 3'b000);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_eq("abort_in_wait", 64'(pready[1]), 64'd0);
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_eq("abort_no_pready", 64'(pready[1]), 64'd0);
    end
    @(posedge clk); #1;
    do_read(1, 12'h010, 32'h1234CC78, 1'b0, "abort_rd");

    // Reset during WAIT of a five-wait-state write.
    do_write(2, 12'h020, 32'h11111111, 4'hF, 3'b000, 1'b0, "rst_init");
    drive_setup(2, 1'b1, 12'h020, 32'h22222222, 4'hF, 3'b000);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_eq("rst_pre_pready", 64'(pready[2]), 64'd0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_wait_pready", 64'(pready[2]), 64'd0);
    check_eq("rst_clears_prdata", 64'(prdata[0]), 64'd0);
    psel = '0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(2, 12'h020, 32'h11111111, 1'b0, "rst_rd");

    // Reset while PREADY is high drops it without waiting for a clock.
    do_write(0, 12'h008, 32'h600DCAFE, 4'hF, 3'b001, 1'b0, "rst2_init");
    drive_setup(0, 1'b1, 12'h008, 32'hBAD0BAD0, 4'hF, 3'b001);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_eq("rst2_pre_pready", 64'(pready[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst2_pready_async", 64'(pready[0]), 64'd0);
    psel = '0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(0, 12'h008, 32'h600DCAFE, 1'b0, "rst2_rd");

    // Fill all words of the small instance, then random back-to-back traffic.
    for (int i = 0; i < 256; i++) begin
      model[i] = {8'hA5, 8'(i), ~16'(i)};
      do_write(0, 12'(i << 2), model[i], 4'hF, 3'b001, 1'b0, "fill");
    end
    for (int n = 0; n < 100; n++) begin
      idx     = int'($urandom_range(0, 299));
      a       = 12'(idx << 2) | 12'($urandom_range(0, 3));
      wr      = 1'($urandom_range(0, 1));
      wd      = $urandom;
      st      = 4'($urandom);
      pr      = 3'($urandom);
      exp_err = (idx >= 256) || (wr && !pr[0] && idx < 16);
      apb_xfer(0, wr, a, wd, st, pr, rd, err, waits);
      check_eq("rand_err", 64'(err), 64'(exp_err));
      check_eq("rand_waits", 64'(waits), 64'd0);
      if (!wr) begin
        check_eq("rand_rdata", 64'(rd), exp_err ? 64'd0 : 64'(model[idx]));
      end else if (!exp_err) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) model[idx][b*8 +: 8] = wd[b*8 +: 8];
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
